// File: rtl/store_sequencer.sv
// Store-instruction control sequencer: a Moore FSM that steps a single-bus datapath
// through fetch (T0..T2) and a base-plus-offset store (T3..T7), with a bounded wait
// on each memory handshake and a sticky error state on timeout.
module store_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mem_ack,
  output logic       IncPC,
  output logic       PCin,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Grb,
  output logic       Gra,
  output logic       BAout,
  output logic       Rout,
  output logic       Yin,
  output logic       Cout,
  output logic       Zin,
  output logic       Zlowout,
  output logic       ADD,
  output logic       Read,
  output logic       read_mem,
  output logic       write_mem,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] step
);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StT7   = 4'd8,
    StDone = 4'd9,
    StErr  = 4'd10
  } state_e;

  typedef struct packed {
    logic inc_pc;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic grb;
    logic gra;
    logic ba_out;
    logic r_out;
    logic y_in;
    logic c_out;
    logic z_in;
    logic zlow_out;
    logic add;
    logic read;
    logic read_mem;
    logic write_mem;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  localparam logic [3:0] WaitMax = 4'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q;

  // Control word for a given state; everything not named is 0.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StT0:   begin c.inc_pc = 1'b1; c.mar_in = 1'b1; c.pc_in = 1'b1; c.busy = 1'b1; end
      StT1:   begin c.read = 1'b1; c.mdr_in = 1'b1; c.read_mem = 1'b1; c.busy = 1'b1; end
      StT2:   begin c.mdr_out = 1'b1; c.ir_in = 1'b1; c.busy = 1'b1; end
      StT3:   begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; c.busy = 1'b1; end
      StT4:   begin c.c_out = 1'b1; c.add = 1'b1; c.z_in = 1'b1; c.busy = 1'b1; end
      StT5:   begin c.zlow_out = 1'b1; c.mar_in = 1'b1; c.busy = 1'b1; end
      // Read stays 0 so MDR loads the store data from the bus.
      StT6:   begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; c.busy = 1'b1; end
      StT7:   begin c.write_mem = 1'b1; c.busy = 1'b1; end
      StDone: c.done = 1'b1;
      StErr:  c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and wait-counter logic; mem_ack wins over the timeout on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0:   begin state_d = StT1; cnt_d = '0; end
      StT1: begin
        if (mem_ack)               state_d = StT2;
        else if (cnt_q == WaitMax) state_d = StErr;
        else                       cnt_d = cnt_q + 4'd1;
      end
      StT2:   state_d = StT3;
      StT3:   state_d = StT4;
      StT4:   state_d = StT5;
      StT5:   state_d = StT6;
      StT6:   begin state_d = StT7; cnt_d = '0; end
      StT7: begin
        if (mem_ack)               state_d = StDone;
        else if (cnt_q == WaitMax) state_d = StErr;
        else                       cnt_d = cnt_q + 4'd1;
      end
      StDone: state_d = StIdle;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers; outputs are the decode of the next state so
  // that after the edge they match the registered state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign IncPC     = ctrl_q.inc_pc;
  assign PCin      = ctrl_q.pc_in;
  assign MARin     = ctrl_q.mar_in;
  assign MDRin     = ctrl_q.mdr_in;
  assign MDRout    = ctrl_q.mdr_out;
  assign IRin      = ctrl_q.ir_in;
  assign Grb       = ctrl_q.grb;
  assign Gra       = ctrl_q.gra;
  assign BAout     = ctrl_q.ba_out;
  assign Rout      = ctrl_q.r_out;
  assign Yin       = ctrl_q.y_in;
  assign Cout      = ctrl_q.c_out;
  assign Zin       = ctrl_q.z_in;
  assign Zlowout   = ctrl_q.zlow_out;
  assign ADD       = ctrl_q.add;
  assign Read      = ctrl_q.read;
  assign read_mem  = ctrl_q.read_mem;
  assign write_mem = ctrl_q.write_mem;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign err       = ctrl_q.err;
  assign step      = state_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: expected per-cycle output vectors are queued
// when a sequence is launched and popped/compared each cycle on the falling edge.
module tb_store_sequencer;

  logic clk = 1'b0;
  logic reset, start, mem_ack;
  logic IncPC, PCin, MARin, MDRin, MDRout, IRin, Grb, Gra, BAout, Rout, Yin;
  logic Cout, Zin, Zlowout, ADD, Read, read_mem, write_mem, busy, done, err;
  logic [3:0] step;

  int errors = 0;
  int checks = 0;
  logic [24:0] sb[$];
  int rd_cnt, wr_cnt, idx, done_idx;

  store_sequencer #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ack(mem_ack),
    .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Grb(Grb), .Gra(Gra), .BAout(BAout), .Rout(Rout), .Yin(Yin),
    .Cout(Cout), .Zin(Zin), .Zlowout(Zlowout), .ADD(ADD), .Read(Read),
    .read_mem(read_mem), .write_mem(write_mem), .busy(busy), .done(done), .err(err),
    .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] dut_vec();
    return {step, IncPC, PCin, MARin, MDRin, MDRout, IRin, Grb, Gra, BAout, Rout, Yin,
            Cout, Zin, Zlowout, ADD, Read, read_mem, write_mem, busy, done, err};
  endfunction

  // Reference control table written from the state descriptions.
  function automatic logic [24:0] exp_vec(int s);
    logic inc, pci, mari, mdri, mdro, iri, gb, ga, bao, ro, yi, co, zi, zlo, ad;
    logic rd, rm, wm, bz, dn, er;
    {inc, pci, mari, mdri, mdro, iri, gb, ga, bao, ro, yi, co, zi, zlo, ad} = '0;
    {rd, rm, wm, bz, dn, er} = '0;
    bz = (s >= 1 && s <= 8);
    case (s)
      1:  begin inc = 1; pci = 1; mari = 1; end
      2:  begin rd = 1; mdri = 1; rm = 1; end
      3:  begin mdro = 1; iri = 1; end
      4:  begin gb = 1; bao = 1; yi = 1; end
      5:  begin co = 1; ad = 1; zi = 1; end
      6:  begin zlo = 1; mari = 1; end
      7:  begin ga = 1; ro = 1; mdri = 1; end
      8:  wm = 1;
      9:  dn = 1;
      10: er = 1;
      default: ;
    endcase
    return {4'(s), inc, pci, mari, mdri, mdro, iri, gb, ga, bao, ro, yi, co, zi, zlo, ad,
            rd, rm, wm, bz, dn, er};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_run(input int s, input int n);
    for (int i = 0; i < n; i++) sb.push_back(exp_vec(s));
  endtask

  // Compare current outputs with the queue head, then advance one clock.
  task automatic pop_check(input string tag);
    logic [24:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed=scoreboard-empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(dut_vec()), 32'(e));
    end
    chk({tag, "_mem_excl"}, 32'(read_mem & write_mem), 32'd0);
    if (MDRin && Read) chk({tag, "_mdr_read"}, 32'(step), 32'd2);
    rd_cnt += int'(read_mem);
    wr_cnt += int'(write_mem);
    if (done) done_idx = idx;
    idx++;
    cyc();
  endtask

  task automatic clr_stats();
    rd_cnt = 0; wr_cnt = 0; idx = 0; done_idx = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    cyc();
    reset = 1'b0;

    // Reset state
    push_run(0, 1);
    pop_check("reset");

    // Nominal sequence with mem_ack tied high
    clr_stats();
    mem_ack = 1'b1; start = 1'b1;
    for (int s = 1; s <= 9; s++) push_run(s, 1);
    push_run(0, 1);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) pop_check("nominal");
    chk("nominal_done_idx", 32'(done_idx), 32'd8);

    // Memory stalls: 3 low cycles in T1, 2 in T7
    clr_stats();
    mem_ack = 1'b0; start = 1'b1;
    push_run(1, 1); push_run(2, 4);
    for (int s = 3; s <= 7; s++) push_run(s, 1);
    push_run(8, 3); push_run(9, 1); push_run(0, 1);
    cyc();
    start = 1'b0;
    pop_check("stall_t0");
    for (int i = 0; i < 3; i++) pop_check("stall_t1");
    mem_ack = 1'b1;
    pop_check("stall_t1_ack");
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) pop_check("stall_mid");
    for (int i = 0; i < 2; i++) pop_check("stall_t7");
    mem_ack = 1'b1;
    pop_check("stall_t7_ack");
    pop_check("stall_done");
    pop_check("stall_idle");
    chk("stall_done_idx", 32'(done_idx), 32'd13);
    chk("stall_read_mem_cycles", 32'(rd_cnt), 32'd4);
    chk("stall_write_mem_cycles", 32'(wr_cnt), 32'd3);

    // Timeout in T7 -> sticky ERR
    clr_stats();
    mem_ack = 1'b1; start = 1'b1;
    for (int s = 1; s <= 7; s++) push_run(s, 1);
    push_run(8, 16); push_run(10, 3);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 7; i++) pop_check("tmo_pre");
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) pop_check("tmo_t7");
    pop_check("tmo_err");
    start = 1'b1; mem_ack = 1'b1;
    pop_check("tmo_err_hold");
    pop_check("tmo_err_hold2");
    start = 1'b0; mem_ack = 1'b0;
    do_reset();
    push_run(0, 1);
    pop_check("tmo_reset");

    // mem_ack arrives on the WAIT_MAX cycle of T1
    clr_stats();
    mem_ack = 1'b0; start = 1'b1;
    push_run(1, 1); push_run(2, 16);
    for (int s = 3; s <= 9; s++) push_run(s, 1);
    push_run(0, 1);
    cyc();
    start = 1'b0;
    pop_check("edge_t0");
    for (int i = 0; i < 15; i++) pop_check("edge_t1");
    mem_ack = 1'b1;
    pop_check("edge_t1_last");
    for (int i = 0; i < 8; i++) pop_check("edge_rest");
    chk("edge_read_mem_cycles", 32'(rd_cnt), 32'd16);

    // Reset during T5, then a clean run with a start pulse in T3
    clr_stats();
    mem_ack = 1'b1; start = 1'b1;
    for (int s = 1; s <= 6; s++) push_run(s, 1);
    push_run(0, 1);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) pop_check("rst_mid_pre");
    reset = 1'b1;
    pop_check("rst_mid_t5");
    reset = 1'b0;
    pop_check("rst_mid_idle");
    start = 1'b1;
    for (int s = 1; s <= 9; s++) push_run(s, 1);
    push_run(0, 2);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) pop_check("rerun");
    start = 1'b1;
    pop_check("rerun_t3_start");
    start = 1'b0;
    for (int i = 0; i < 7; i++) pop_check("rerun_tail");

    // start held high: back-to-back sequences
    clr_stats();
    mem_ack = 1'b1; start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int s = 1; s <= 9; s++) push_run(s, 1);
      push_run(0, 1);
    end
    push_run(0, 1);
    cyc();
    for (int i = 0; i < 20; i++) begin
      if (i == 19) start = 1'b0;
      pop_check("b2b");
    end
    pop_check("b2b_idle");
    chk("b2b_write_mem_cycles", 32'(wr_cnt), 32'd2);
    chk("b2b_queue_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one store-instruction sequence; sampled in IDLE only
- mem_ack  in  1  memory has completed the current read or write
- IncPC, PCin, MARin, MDRin, MDRout, IRin  out  1 each  datapath register controls
- Grb, Gra, BAout, Rout, Yin, Cout, Zin, Zlowout, ADD  out  1 each  datapath register, bus and ALU controls
- Read, read_mem, write_mem  out  1 each  MDR source select and memory strobes
- busy  out  1  sequence in progress (states T0..T7)
- done  out  1  one-cycle completion pulse
- err  out  1  memory timeout; sticky until reset
- step  out  4  current state code
REQ-003 Parameter WAIT_MAX (default 15) SHALL set the maximum number of cycles spent waiting for mem_ack.

Function
REQ-004 The block SHALL be a Moore FSM:
- all outputs decode only the registered state;
- all unlisted controls are 0 in every state.
REQ-005 State codes (step) SHALL be: IDLE=0, T0..T7=1..8, DONE=9, ERR=10.
REQ-006 IDLE SHALL drive no controls and SHALL move to T0 when start=1; otherwise it stays in IDLE.
REQ-007 T0 SHALL assert IncPC, MARin and PCin, then advance unconditionally.
REQ-008 T1 SHALL assert Read, MDRin and read_mem, and SHALL hold until mem_ack=1.
REQ-009 T2 SHALL assert MDRout and IRin.
REQ-010 T3 SHALL assert Grb, BAout and Yin.
REQ-011 T4 SHALL assert Cout, ADD and Zin.
REQ-012 T5 SHALL assert Zlowout and MARin.
REQ-013 T6 SHALL assert Gra, Rout and MDRin, with Read=0 so that MDR loads from the bus.
REQ-014 T7 SHALL assert write_mem and SHALL hold until mem_ack=1.
REQ-015 States T2..T6 SHALL each last exactly one cycle.
REQ-016 Sequence length:
- with mem_ack already high on entry to T1 and T7, T0 to DONE SHALL take 8 cycles;
- each cycle mem_ack is low adds one cycle.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Wait counter (4 bits):
- clears on entry to T1 and on entry to T7;
- increments on each T1/T7 cycle with mem_ack=0;
- when it equals WAIT_MAX with mem_ack=0, the next state SHALL be ERR.
REQ-019 mem_ack=1 on the same cycle the counter reaches WAIT_MAX SHALL take priority: the FSM advances normally and does not enter ERR.
REQ-020 ERR SHALL assert err, deassert busy and every datapath/memory control, and remain in ERR until reset.
REQ-021 Input qualification:
- start SHALL be ignored outside IDLE;
- mem_ack SHALL be ignored outside T1 and T7.
REQ-022 read_mem and write_mem SHALL never be asserted in the same cycle.
REQ-023 MDRin with Read=1 SHALL occur only in T1.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE from any state, including mid-sequence and ERR.
REQ-025 After reset:
- wait counter = 0;
- every output is 0, with step=0, busy=0, done=0, err=0.
REQ-026 reset SHALL take priority over start and mem_ack on the same edge.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- start=1 for one cycle, mem_ack tied high -> step runs 1..9 on consecutive cycles, done pulses on cycle 9, then step=0; verify each T-state's asserted controls exactly.
- mem_ack low for 3 cycles in T1 and 2 cycles in T7 -> DONE reached 13 cycles after start; read_mem high for 4 cycles, write_mem high for 3 cycles.
- mem_ack never asserted in T7 -> ERR after 16 T7 cycles; err=1, write_mem=0, busy=0; stays in ERR until reset, then step=0.
- mem_ack rises exactly on the WAIT_MAX cycle in T1 -> advances to T2, err stays 0.
- reset asserted during T5 -> next cycle step=0 and all outputs 0; a fresh start then completes normally.
- start held high continuously -> back-to-back sequences separated by the DONE and IDLE cycles; start pulses during T3 are ignored.
